// File: rtl/user_dma_tag_manager.sv
// rtl/user_dma_tag_manager.sv - round-robin read tag allocator and completion router for a DMA engine
module user_dma_tag_manager #(
  parameter int NUM_SLAVES = 4,
  parameter int NUM_TAGS   = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 12,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_SLAVES-1:0]            i_slave_rd_req,
  input  logic [ADDR_WIDTH*NUM_SLAVES-1:0] i_slave_rd_addr,
  input  logic [LEN_WIDTH*NUM_SLAVES-1:0]  i_slave_rd_len,
  output logic [NUM_SLAVES-1:0]            o_slave_rd_ack,
  output logic                             o_dma_req,
  input  logic                             i_dma_ack,
  output logic [ADDR_WIDTH-1:0]            o_dma_req_addr,
  output logic [LEN_WIDTH-1:0]             o_dma_req_len,
  output logic [TAG_WIDTH-1:0]             o_dma_req_tag,
  input  logic                             i_cpl_valid,
  input  logic [TAG_WIDTH-1:0]             i_cpl_tag,
  input  logic                             i_cpl_last,
  input  logic [DATA_WIDTH-1:0]            i_cpl_data,
  output logic [NUM_SLAVES-1:0]            o_slave_cpl_valid,
  output logic [DATA_WIDTH-1:0]            o_slave_cpl_data,
  output logic [TAG_WIDTH-1:0]             o_slave_cpl_tag,
  output logic [$clog2(NUM_TAGS+1)-1:0]    o_outstanding,
  output logic                             o_tag_full,
  output logic                             o_cpl_err
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int OW = $clog2(NUM_TAGS+1);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t              state;
  logic [NUM_TAGS-1:0] busy;
  logic [SW-1:0]       owner [NUM_TAGS];
  logic [SW-1:0]       last_grant;
  logic [SW-1:0]       winner;

  logic                  rr_found;
  logic [SW-1:0]         rr_idx;
  logic [ADDR_WIDTH-1:0] rr_addr;
  logic [LEN_WIDTH-1:0]  rr_len;
  logic                  free_found;
  logic [TAG_WIDTH-1:0]  free_tag;
  logic                  hit_busy;
  logic [SW-1:0]         hit_owner;
  logic                  alloc;
  logic                  cpl_ok;
  logic                  cpl_rel;
  int                    rr_target;

  // Round-robin pick: first requester at or after last_grant+1, wrapping
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = '0;
    rr_target = 0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rr_target = int'(last_grant) + 1 + i;
      if (rr_target >= NUM_SLAVES) rr_target = rr_target - NUM_SLAVES;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (!rr_found && s == rr_target && i_slave_rd_req[s]) begin
          rr_found = 1'b1;
          rr_idx   = SW'(s);
        end
      end
    end
    rr_addr = '0;
    rr_len  = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (rr_idx == SW'(s)) begin
        rr_addr = i_slave_rd_addr[s*ADDR_WIDTH +: ADDR_WIDTH];
        rr_len  = i_slave_rd_len[s*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Lowest-index free tag from the registered bitmap, and lookup of the completing tag
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    hit_busy   = 1'b0;
    hit_owner  = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (!free_found && !busy[t]) begin
        free_found = 1'b1;
        free_tag   = TAG_WIDTH'(t);
      end
      if (i_cpl_tag == TAG_WIDTH'(t)) begin
        hit_busy  = busy[t];
        hit_owner = owner[t];
      end
    end
  end

  // Out-of-range tags never match above, so they fall out as "not busy"
  assign alloc      = (state == REQ) && i_dma_ack;
  assign cpl_ok     = i_cpl_valid && hit_busy;
  assign cpl_rel    = cpl_ok && i_cpl_last;
  assign o_tag_full = &busy;

  // Request FSM: latch winner and fields, present to Tx engine, pulse the slave ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      last_grant     <= SW'(NUM_SLAVES-1);
      winner         <= '0;
      o_dma_req      <= 1'b0;
      o_dma_req_addr <= '0;
      o_dma_req_len  <= '0;
      o_dma_req_tag  <= '0;
      o_slave_rd_ack <= '0;
    end else begin
      o_slave_rd_ack <= '0;
      unique case (state)
        IDLE: begin
          if (rr_found && free_found) begin
            winner         <= rr_idx;
            o_dma_req_addr <= rr_addr;
            o_dma_req_len  <= rr_len;
            o_dma_req_tag  <= free_tag;
            o_dma_req      <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          if (i_dma_ack) begin
            o_dma_req  <= 1'b0;
            last_grant <= winner;
            for (int s = 0; s < NUM_SLAVES; s++) begin
              o_slave_rd_ack[s] <= (winner == SW'(s));
            end
            state <= ACK;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Busy bitmap, owner table and outstanding count; alloc and release may share an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy          <= '0;
      o_outstanding <= '0;
      for (int t = 0; t < NUM_TAGS; t++) owner[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (alloc && o_dma_req_tag == TAG_WIDTH'(t)) begin
          busy[t]  <= 1'b1;
          owner[t] <= winner;
        end else if (cpl_rel && i_cpl_tag == TAG_WIDTH'(t)) begin
          busy[t] <= 1'b0;
        end
      end
      case ({alloc, cpl_rel})
        2'b10:   o_outstanding <= o_outstanding + OW'(1);
        2'b01:   o_outstanding <= o_outstanding - OW'(1);
        default: o_outstanding <= o_outstanding;
      endcase
    end
  end

  // Completion routing to the owning slave, one cycle later; stray completions flag a sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_slave_cpl_valid <= '0;
      o_slave_cpl_data  <= '0;
      o_slave_cpl_tag   <= '0;
      o_cpl_err         <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        o_slave_cpl_valid[s] <= cpl_ok && (hit_owner == SW'(s));
      end
      if (cpl_ok) begin
        o_slave_cpl_data <= i_cpl_data;
        o_slave_cpl_tag  <= i_cpl_tag;
      end
      if (i_cpl_valid && !hit_busy) o_cpl_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_user_dma_tag_manager.sv
// tb/tb_user_dma_tag_manager.sv - self-checking bench for user_dma_tag_manager
module tb_user_dma_tag_manager;

  localparam int NS = 4;
  localparam int NT = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [NS-1:0] i_slave_rd_req = '0;
  logic [32*NS-1:0] i_slave_rd_addr;
  logic [12*NS-1:0] i_slave_rd_len;
  logic [NS-1:0] o_slave_rd_ack;
  logic          o_dma_req;
  logic          i_dma_ack = 1'b0;
  logic [31:0]   o_dma_req_addr;
  logic [11:0]   o_dma_req_len;
  logic [7:0]    o_dma_req_tag;
  logic          i_cpl_valid = 1'b0;
  logic [7:0]    i_cpl_tag = '0;
  logic          i_cpl_last = 1'b0;
  logic [63:0]   i_cpl_data = '0;
  logic [NS-1:0] o_slave_cpl_valid;
  logic [63:0]   o_slave_cpl_data;
  logic [7:0]    o_slave_cpl_tag;
  logic [3:0]    o_outstanding;
  logic          o_tag_full;
  logic          o_cpl_err;

  user_dma_tag_manager #(.NUM_SLAVES(NS), .NUM_TAGS(NT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_slave_rd_req(i_slave_rd_req), .i_slave_rd_addr(i_slave_rd_addr),
    .i_slave_rd_len(i_slave_rd_len), .o_slave_rd_ack(o_slave_rd_ack),
    .o_dma_req(o_dma_req), .i_dma_ack(i_dma_ack),
    .o_dma_req_addr(o_dma_req_addr), .o_dma_req_len(o_dma_req_len),
    .o_dma_req_tag(o_dma_req_tag),
    .i_cpl_valid(i_cpl_valid), .i_cpl_tag(i_cpl_tag), .i_cpl_last(i_cpl_last),
    .i_cpl_data(i_cpl_data),
    .o_slave_cpl_valid(o_slave_cpl_valid), .o_slave_cpl_data(o_slave_cpl_data),
    .o_slave_cpl_tag(o_slave_cpl_tag), .o_outstanding(o_outstanding),
    .o_tag_full(o_tag_full), .o_cpl_err(o_cpl_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  // Spec-level model: which tags are held and by whom, who was served last
  bit          m_busy [NT];
  int          m_owner [NT];
  int          m_last = NS-1;
  bit          m_err = 1'b0;
  logic [NS-1:0] exp_cv = '0;
  logic [63:0] exp_data = '0;
  logic [7:0]  exp_tag = '0;
  int          pend_slave = 0;
  int          pend_tag = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int t = 0; t < NT; t++) c += m_busy[t];
    return c;
  endfunction

  function automatic int m_free();
    for (int t = 0; t < NT; t++) if (!m_busy[t]) return t;
    return -1;
  endfunction

  function automatic int m_rr(input logic [NS-1:0] r);
    for (int i = 1; i <= NS; i++) if (r[(m_last + i) % NS]) return (m_last + i) % NS;
    return -1;
  endfunction

  function automatic logic [31:0] addr_of(input int s);
    return 32'h8000_0000 + 32'(s) * 32'h1000;
  endfunction

  function automatic logic [11:0] len_of(input int s);
    return 12'h040 + 12'(s);
  endfunction

  // Model update on the same edge the DUT acts on
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int t = 0; t < NT; t++) begin m_busy[t] = 1'b0; m_owner[t] = 0; end
      m_last = NS-1;
      m_err  = 1'b0;
      exp_cv = '0;
    end else begin
      exp_cv = '0;
      if (i_cpl_valid) begin
        if (i_cpl_tag < NT && m_busy[i_cpl_tag]) begin
          exp_cv   = NS'(1) << m_owner[i_cpl_tag];
          exp_data = i_cpl_data;
          exp_tag  = i_cpl_tag;
          if (i_cpl_last) m_busy[i_cpl_tag] = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (i_dma_ack) begin
        m_busy[pend_tag]  = 1'b1;
        m_owner[pend_tag] = pend_slave;
        m_last            = pend_slave;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge i_clk) begin
    if (run_chk) begin
      chk("outstanding", 64'(o_outstanding), 64'(m_count()));
      chk("tag_full", 64'(o_tag_full), 64'(m_count() == NT));
      chk("cpl_err", 64'(o_cpl_err), 64'(m_err));
      chk("cpl_valid", 64'(o_slave_cpl_valid), 64'(exp_cv));
      if (exp_cv != '0) begin
        chk("cpl_data", o_slave_cpl_data, exp_data);
        chk("cpl_tag", 64'(o_slave_cpl_tag), 64'(exp_tag));
      end
    end
  end

  // One grant: wait for the request, hold a cycle, ack (optionally with a release), check the ack pulse
  task automatic do_grant(input bit sim_cpl, input logic [7:0] ctag, output int gs, output int gt);
    int n;
    gs = m_rr(i_slave_rd_req);
    gt = m_free();
    n = 0;
    while (o_dma_req !== 1'b1 && n < 20) begin @(negedge i_clk); n++; end
    chk("dma_req_seen", 64'(o_dma_req), 64'd1);
    chk("req_tag", 64'(o_dma_req_tag), 64'(gt));
    chk("req_addr", 64'(o_dma_req_addr), 64'(addr_of(gs)));
    chk("req_len", 64'(o_dma_req_len), 64'(len_of(gs)));
    @(negedge i_clk);
    chk("req_hold", 64'(o_dma_req), 64'd1);
    chk("req_tag_hold", 64'(o_dma_req_tag), 64'(gt));
    pend_slave = gs;
    pend_tag   = gt;
    i_dma_ack  = 1'b1;
    if (sim_cpl) begin
      i_cpl_valid = 1'b1; i_cpl_tag = ctag; i_cpl_last = 1'b1; i_cpl_data = 64'h5151_0000_0000_0000;
    end
    @(negedge i_clk);
    i_dma_ack = 1'b0; i_cpl_valid = 1'b0; i_cpl_last = 1'b0;
    chk("rd_ack_pulse", 64'(o_slave_rd_ack), 64'(NS'(1) << gs));
    chk("req_drop", 64'(o_dma_req), 64'd0);
    i_slave_rd_req[gs] = 1'b0;
    @(negedge i_clk);
    chk("rd_ack_single", 64'(o_slave_rd_ack), 64'd0);
  endtask

  task automatic send_cpl(input logic [7:0] tag, input bit last, input logic [63:0] data);
    i_cpl_valid = 1'b1; i_cpl_tag = tag; i_cpl_last = last; i_cpl_data = data;
    @(negedge i_clk);
    i_cpl_valid = 1'b0; i_cpl_last = 1'b0;
  endtask

  int gs, gt;
  int exp_slaves [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int s = 0; s < NS; s++) begin
      i_slave_rd_addr[s*32 +: 32] = addr_of(s);
      i_slave_rd_len[s*12 +: 12]  = len_of(s);
    end
    repeat (3) @(negedge i_clk);
    chk("rst_dma_req", 64'(o_dma_req), 64'd0);
    chk("rst_outstanding", 64'(o_outstanding), 64'd0);
    chk("rst_tag_full", 64'(o_tag_full), 64'd0);
    chk("rst_cpl_err", 64'(o_cpl_err), 64'd0);
    chk("rst_rd_ack", 64'(o_slave_rd_ack), 64'd0);
    i_rst_n = 1'b1;
    run_chk = 1'b1;

    // Round-robin with every slave requesting
    for (int k = 0; k < 5; k++) begin
      i_slave_rd_req = 4'hF;
      do_grant(1'b0, 8'd0, gs, gt);
      chk("rr_slave_lit", 64'(gs), 64'(exp_slaves[k]));
      chk("rr_tag_lit", 64'(gt), 64'(k));
    end
    chk("rr_outstanding_lit", 64'(o_outstanding), 64'd5);

    // Routing: tag 5 to slave 3, then its last beat, then a back-to-back burst on tag 1
    i_slave_rd_req = 4'b1000;
    do_grant(1'b0, 8'd0, gs, gt);
    chk("route_grant_lit", 64'(gt), 64'd5);
    send_cpl(8'd5, 1'b0, 64'hDEAD_BEEF_0000_0001);
    chk("route_valid_lit", 64'(o_slave_cpl_valid), 64'b1000);
    chk("route_data_lit", o_slave_cpl_data, 64'hDEAD_BEEF_0000_0001);
    send_cpl(8'd5, 1'b1, 64'hDEAD_BEEF_0000_0002);
    chk("route_dec_lit", 64'(o_outstanding), 64'd5);
    for (int b = 0; b < 3; b++) begin
      i_cpl_valid = 1'b1; i_cpl_tag = 8'd1; i_cpl_last = (b == 2); i_cpl_data = 64'(b) + 64'h100;
      @(negedge i_clk);
      chk("burst_valid_lit", 64'(o_slave_cpl_valid), 64'b0010);
    end
    i_cpl_valid = 1'b0; i_cpl_last = 1'b0;
    chk("burst_dec_lit", 64'(o_outstanding), 64'd4);

    // Errors: free tag 7, out-of-range tag 9
    send_cpl(8'd7, 1'b1, 64'h77);
    chk("err_novalid_lit", 64'(o_slave_cpl_valid), 64'd0);
    chk("err_set_lit", 64'(o_cpl_err), 64'd1);
    send_cpl(8'd9, 1'b0, 64'h99);
    chk("err_range_lit", 64'(o_slave_cpl_valid), 64'd0);
    repeat (2) @(negedge i_clk);
    chk("err_sticky_lit", 64'(o_cpl_err), 64'd1);

    // Exhaustion: slave 1 takes the remaining four tags, the next request stalls
    for (int k = 0; k < 4; k++) begin
      i_slave_rd_req[1] = 1'b1;
      do_grant(1'b0, 8'd0, gs, gt);
      chk("full_slave_lit", 64'(gs), 64'd1);
    end
    chk("full_outstanding_lit", 64'(o_outstanding), 64'd8);
    chk("full_flag_lit", 64'(o_tag_full), 64'd1);
    i_slave_rd_req[1] = 1'b1;
    repeat (6) begin
      @(negedge i_clk);
      chk("full_stall", 64'(o_dma_req), 64'd0);
    end
    send_cpl(8'd2, 1'b1, 64'h22);
    do_grant(1'b0, 8'd0, gs, gt);
    chk("refill_tag_lit", 64'(gt), 64'd2);

    // Simultaneous ack and release
    send_cpl(8'd3, 1'b1, 64'h33);
    i_slave_rd_req[0] = 1'b1;
    do_grant(1'b1, 8'd0, gs, gt);
    chk("simul_tag_lit", 64'(gt), 64'd3);
    chk("simul_outstanding_lit", 64'(o_outstanding), 64'd7);
    i_slave_rd_req[2] = 1'b1;
    do_grant(1'b0, 8'd0, gs, gt);
    chk("simul_next_lit", 64'(gt), 64'd0);

    // Reset while a request is pending with three tags held
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_slave_rd_req = 4'hF;
    for (int k = 0; k < 3; k++) do_grant(1'b0, 8'd0, gs, gt);
    chk("pre_rst_outstanding_lit", 64'(o_outstanding), 64'd3);
    begin
      int n = 0;
      while (o_dma_req !== 1'b1 && n < 20) begin @(negedge i_clk); n++; end
    end
    chk("pre_rst_req_lit", 64'(o_dma_req), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(o_dma_req), 64'd0);
    chk("mid_rst_addr", 64'(o_dma_req_addr), 64'd0);
    chk("mid_rst_len", 64'(o_dma_req_len), 64'd0);
    chk("mid_rst_tag", 64'(o_dma_req_tag), 64'd0);
    chk("mid_rst_outstanding", 64'(o_outstanding), 64'd0);
    chk("mid_rst_full", 64'(o_tag_full), 64'd0);
    chk("mid_rst_err", 64'(o_cpl_err), 64'd0);
    chk("mid_rst_cpl", 64'(o_slave_cpl_data), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_slave_rd_req = 4'hF;
    do_grant(1'b0, 8'd0, gs, gt);
    chk("post_rst_slave_lit", 64'(gs), 64'd0);
    chk("post_rst_tag_lit", 64'(gt), 64'd0);
    send_cpl(8'd1, 1'b1, 64'h11);
    chk("stale_novalid_lit", 64'(o_slave_cpl_valid), 64'd0);
    chk("stale_err_lit", 64'(o_cpl_err), 64'd1);
    i_slave_rd_req = '0;
    repeat (3) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
